entrada_io_responder: RTL and testbench
=======================================

Name: entrada_io_responder

Overview:
- Input-side responder for the CPU's IN instruction.
- When the CPU requests input, the block synchronizes and debounces the board button, waits for a clean press, and latches the 4-bit switch value.
- It then presents the value, zero-extended to 32 bits, to the register write-back path and pulses a release to the halt logic.
- It sits between the board pins (button, switches) and the CPU IO/halt logic, and replaces the raw button path.

Parameters:
- DEB_CNT, 50000: number of consecutive stable cycles of the synchronized button required before the debounced level changes.
- CNT_W, 16: width of the debounce counter; must satisfy 2^CNT_W > DEB_CNT.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- botaoPlaca  in  1  raw board button, asynchronous, active-high when pressed.
- entradaDeDados  in  4  board switches, quasi-static.
- pedidoIN  in  1  level from the control unit, held high while the CPU is stalled on IN.
- dadoLido  out  32  captured switch value, zero-extended in bits [31:4].
- dadoValido  out  1  high while dadoLido holds a value for the current request.
- liberaParada  out  1  one-cycle pulse that releases the halt.
- aguardando  out  1  LED: request pending, waiting for press.
- botaoLimpo  out  1  debounced button level, for observation.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - sync flops and botaoLimpo = 0; debounce counter = 0; dadoLido = 0.
  - dadoValido = 0, liberaParada = 0, aguardando = 0; FSM = OCIOSO.
- Synchronizer: two flops on botaoPlaca produce s2. Entradas are sampled directly, because they are only captured in the CAPTURA state.
- Debounce:
  - If s2 == botaoLimpo, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEB_CNT-1 and s2 still differs, botaoLimpo <= s2 and the counter clears.
  - Total latency from a pin edge to a botaoLimpo change is DEB_CNT+2 cycles.
  - Any bounce (s2 returning to botaoLimpo) clears the counter.
- pressEvt is a one-cycle pulse, asserted the cycle after botaoLimpo goes 0->1.
- FSM:
  - OCIOSO: outputs idle. On pedidoIN=1, go to ESPERA_SOLTO.
  - ESPERA_SOLTO: aguardando=1. If botaoLimpo=0, go to ESPERA_PRESS. A press already held when the request starts is never accepted; the button must be released first.
  - ESPERA_PRESS: aguardando=1. On pressEvt, go to CAPTURA.
  - CAPTURA (1 cycle): dadoLido <= {28'b0, entradaDeDados}; liberaParada=1 on this cycle only; go to ENTREGA.
  - ENTREGA: dadoValido=1, aguardando=0. dadoLido is stable. On pedidoIN=0, go to OCIOSO and clear dadoValido; dadoLido keeps its last value.
- Abort: if pedidoIN falls in ESPERA_SOLTO or ESPERA_PRESS, go to OCIOSO with no capture and no pulse.
- pedidoIN held high after ENTREGA: no new capture. A new request requires pedidoIN to go low, then high again.
- Simultaneous pedidoIN fall and pressEvt in ESPERA_PRESS: the abort wins.
- Presses while in OCIOSO or ENTREGA are ignored; botaoLimpo still tracks the button.
- Reset mid-operation: immediate return to reset values, even during CAPTURA; no liberaParada pulse escapes.
- Exactly one liberaParada pulse per accepted request.

Test Plan (DEB_CNT=4):
- Reset: hold reset=0 with the button toggling -> all outputs 0. Release reset -> FSM in OCIOSO; botaoLimpo stays 0 until the button is stable for 4 cycles.
- Basic IN:
  - Stimulus: switches=4'hA; pedidoIN=1; clean press of 10 cycles.
  - botaoLimpo rises 6 cycles after the pin edge.
  - liberaParada is a single pulse, 2 cycles after botaoLimpo rises.
  - dadoLido=32'h0000000A with dadoValido=1; on pedidoIN=0, dadoValido drops.
- Bounce: the pin toggles every 2 cycles for 20 cycles, then holds high. botaoLimpo stays 0 until the pin has been stable for 4 cycles, then rises once. Exactly one capture occurs.
- Held button: button already pressed (botaoLimpo=1) when pedidoIN rises; switches=4'h3. No capture while held. Release, then press again -> dadoLido=32'h3, one pulse.
- Abort: pedidoIN=1, then drop to 0 before the press; later press with switches=4'h7. No pulse, dadoValido=0, dadoLido unchanged.
- Reset mid-request: reset=0 asserted in ESPERA_PRESS, press during reset. No liberaParada, dadoLido=0. After release, a new request works normally.

Source files
------------

// File: rtl/entrada_io_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_io_responder_if : CPU-side IN handshake (request, data, release)
// Rev 1.0
// ---------------------------------------------------------------------------
interface entrada_io_responder_if;
  logic        pedidoIN;
  logic [31:0] dadoLido;
  logic        dadoValido;
  logic        liberaParada;

  modport master (
    output pedidoIN,
    input  dadoLido,
    input  dadoValido,
    input  liberaParada
  );

  modport slave (
    input  pedidoIN,
    output dadoLido,
    output dadoValido,
    output liberaParada
  );
endinterface
`default_nettype wire

// File: rtl/entrada_io_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// entrada_io_responder : debounces the board button and answers a CPU IN
//                        request with the latched 4-bit switch value
// Rev 1.0
// ---------------------------------------------------------------------------
module entrada_io_responder #(
  parameter int DEB_CNT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  botaoPlaca,
  input  logic [3:0]            entradaDeDados,
  entrada_io_responder_if.slave cpu,
  output logic                  aguardando,
  output logic                  botaoLimpo
);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ESPERA_SOLTO = 3'd1,
    ESPERA_PRESS = 3'd2,
    CAPTURA      = 3'd3,
    ENTREGA      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic             limpo_q, limpo_d;
  logic             limpo_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dado_q, dado_d;

  // The debounced level only flips after DEB_CNT consecutive differing samples.
  always_comb begin
    limpo_d = limpo_q;
    cnt_d   = '0;
    if (s2_q != limpo_q) begin
      if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        limpo_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      limpo_q     <= 1'b0;
      limpo_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
      dado_q      <= '0;
      state_q     <= OCIOSO;
    end else begin
      s1_q        <= botaoPlaca;
      s2_q        <= s1_q;
      limpo_q     <= limpo_d;
      limpo_dly_q <= limpo_q;
      press_q     <= limpo_q & ~limpo_dly_q;
      cnt_q       <= cnt_d;
      dado_q      <= dado_d;
      state_q     <= state_d;
    end
  end

  // Abort checks come first so a falling request beats a coincident press.
  always_comb begin
    state_d          = state_q;
    dado_d           = dado_q;
    aguardando       = 1'b0;
    cpu.liberaParada = 1'b0;
    cpu.dadoValido   = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (cpu.pedidoIN) state_d = ESPERA_SOLTO;
      end
      ESPERA_SOLTO: begin
        aguardando = 1'b1;
        if (!cpu.pedidoIN)     state_d = OCIOSO;
        else if (!limpo_q)     state_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        aguardando = 1'b1;
        if (!cpu.pedidoIN)     state_d = OCIOSO;
        else if (press_q)      state_d = CAPTURA;
      end
      CAPTURA: begin
        cpu.liberaParada = 1'b1;
        dado_d           = {28'b0, entradaDeDados};
        state_d          = ENTREGA;
      end
      ENTREGA: begin
        cpu.dadoValido = 1'b1;
        if (!cpu.pedidoIN) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  assign cpu.dadoLido = dado_q;
  assign botaoLimpo   = limpo_q;

endmodule
`default_nettype wire

// File: tb/tb_entrada_io_responder.sv
`default_nettype none
// Testbench for entrada_io_responder: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the IN handshake.
`timescale 1ns/1ps
module tb_entrada_io_responder;
  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       botaoPlaca = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       aguardando, botaoLimpo;
  int         checks = 0;
  int         errors = 0;

  entrada_io_responder_if cpu_if();

  entrada_io_responder #(.DEB_CNT(DEB), .CNT_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .botaoPlaca     (botaoPlaca),
    .entradaDeDados (sw),
    .cpu            (cpu_if),
    .aguardando     (aguardando),
    .botaoLimpo     (botaoLimpo)
  );

  always #5 clock = ~clock;

  // Model: pin seen two edges late; level flips once the last DEB samples all
  // disagree with it; a press is recognised one edge after the level rises.
  logic           m_p1 = 0, m_p2 = 0, m_limpo = 0, m_limpo_old = 0, m_pe = 0;
  logic [DEB-1:0] m_win = '0;
  logic           m_pending = 0, m_released = 0, m_capture = 0, m_delivered = 0;
  logic [31:0]    m_data = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_p1 <= 0; m_p2 <= 0; m_limpo <= 0; m_limpo_old <= 0; m_pe <= 0; m_win <= '0;
      m_pending <= 0; m_released <= 0; m_capture <= 0; m_delivered <= 0; m_data <= '0;
    end else begin
      m_p1  <= botaoPlaca;
      m_p2  <= m_p1;
      m_win <= {m_win[DEB-2:0], m_p2};
      if ({m_win[DEB-2:0], m_p2} == {DEB{~m_limpo}}) m_limpo <= ~m_limpo;
      m_limpo_old <= m_limpo;
      m_pe        <= m_limpo && !m_limpo_old;
      if (m_capture) begin
        m_capture <= 0; m_delivered <= 1; m_data <= {28'b0, sw};
      end else if (m_delivered) begin
        if (!cpu_if.pedidoIN) m_delivered <= 0;
      end else if (m_pending) begin
        if (!cpu_if.pedidoIN) m_pending <= 0;
        else if (!m_released) begin
          if (!m_limpo) m_released <= 1;
        end else if (m_pe) begin
          m_pending <= 0; m_capture <= 1;
        end
      end else if (cpu_if.pedidoIN) begin
        m_pending <= 1; m_released <= 0;
      end
    end
  end

  logic [35:0] obs, exp_v;
  assign obs   = {cpu_if.dadoLido, cpu_if.dadoValido, cpu_if.liberaParada, aguardando, botaoLimpo};
  assign exp_v = {m_data, m_delivered, m_capture, m_pending, m_limpo};

  task automatic test_reset();
    int rise_k = -1;
    reset = 0; cpu_if.pedidoIN = 0;
    for (int k = 0; k < 8; k++) begin
      botaoPlaca = k[0];
      @(negedge clock);
      checks++; if (obs !== 36'h0) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, 36'h0); end
    end
    botaoPlaca = 1; reset = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, exp_v); end
      if (botaoLimpo && rise_k < 0) rise_k = k;
    end
    checks++; if (rise_k !== DEB + 2) begin errors++; $display("FAIL reset_rise_latency got=%0d exp=%0d", rise_k, DEB + 2); end
    botaoPlaca = 0;
    repeat (8) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_settle obs=%h exp=%h", obs, exp_v); end
    end
  endtask

  task automatic test_basic();
    int rise_k = -1, pulse_k = -1, np = 0;
    sw = 4'hA; cpu_if.pedidoIN = 1;
    repeat (4) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL basic_wait obs=%h exp=%h", obs, exp_v); end
    end
    botaoPlaca = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL basic_cycle obs=%h exp=%h", obs, exp_v); end
      if (botaoLimpo && rise_k < 0) rise_k = k;
      if (cpu_if.liberaParada) begin np++; if (pulse_k < 0) pulse_k = k; end
      if (k == 10) botaoPlaca = 0;
    end
    checks++; if (rise_k !== 6) begin errors++; $display("FAIL basic_rise got=%0d exp=6", rise_k); end
    checks++; if (pulse_k !== 8) begin errors++; $display("FAIL basic_pulse_time got=%0d exp=8", pulse_k); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_pulse_count got=%0d exp=1", np); end
    checks++; if ({cpu_if.dadoValido, cpu_if.dadoLido} !== {1'b1, 32'h0000000A}) begin
      errors++; $display("FAIL basic_data got=%b/%h exp=1/0000000a", cpu_if.dadoValido, cpu_if.dadoLido); end
    cpu_if.pedidoIN = 0;
    @(negedge clock);
    checks++; if ({cpu_if.dadoValido, cpu_if.dadoLido} !== {1'b0, 32'h0000000A}) begin
      errors++; $display("FAIL basic_drop got=%b/%h exp=0/0000000a", cpu_if.dadoValido, cpu_if.dadoLido); end
    repeat (8) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL basic_tail obs=%h exp=%h", obs, exp_v); end
    end
  endtask

  task automatic test_bounce();
    int rises = 0, np = 0;
    logic prev = 0;
    sw = 4'h5; cpu_if.pedidoIN = 1;
    for (int k = 0; k < 36; k++) begin
      if (k < 20) botaoPlaca = ((k / 2) % 2 == 0); else botaoPlaca = 1;
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounce_cycle obs=%h exp=%h", obs, exp_v); end
      if (botaoLimpo && !prev) rises++;
      prev = botaoLimpo;
      if (cpu_if.liberaParada) np++;
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
    checks++; if (np !== 1) begin errors++; $display("FAIL bounce_pulses got=%0d exp=1", np); end
    checks++; if (cpu_if.dadoLido !== 32'h5) begin errors++; $display("FAIL bounce_data got=%h exp=00000005", cpu_if.dadoLido); end
    cpu_if.pedidoIN = 0; botaoPlaca = 0;
    repeat (8) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL bounce_tail obs=%h exp=%h", obs, exp_v); end
    end
  endtask

  task automatic test_held();
    int np = 0;
    botaoPlaca = 1;
    repeat (8) @(negedge clock);
    sw = 4'h3; cpu_if.pedidoIN = 1;
    for (int k = 0; k < 46; k++) begin
      if (k == 12) botaoPlaca = 0;
      if (k == 22) botaoPlaca = 1;
      if (k == 34) botaoPlaca = 0;
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL held_cycle obs=%h exp=%h", obs, exp_v); end
      if (cpu_if.liberaParada) begin
        np++;
        checks++; if (k < 22) begin errors++; $display("FAIL held_early_pulse cycle=%0d exp>=22", k); end
      end
    end
    checks++; if (np !== 1) begin errors++; $display("FAIL held_pulses got=%0d exp=1", np); end
    checks++; if (cpu_if.dadoLido !== 32'h3) begin errors++; $display("FAIL held_data got=%h exp=00000003", cpu_if.dadoLido); end
    cpu_if.pedidoIN = 0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_abort();
    int np = 0;
    cpu_if.pedidoIN = 1;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin cpu_if.pedidoIN = 0; sw = 4'h7; botaoPlaca = 1; end
      if (k == 13) botaoPlaca = 0;
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL abort_cycle obs=%h exp=%h", obs, exp_v); end
      if (cpu_if.liberaParada) np++;
    end
    checks++; if (np !== 0) begin errors++; $display("FAIL abort_pulses got=%0d exp=0", np); end
    checks++; if ({cpu_if.dadoValido, cpu_if.dadoLido} !== {1'b0, 32'h3}) begin
      errors++; $display("FAIL abort_data got=%b/%h exp=0/00000003", cpu_if.dadoValido, cpu_if.dadoLido); end
  endtask

  task automatic test_reset_mid();
    int np = 0;
    sw = 4'h9; cpu_if.pedidoIN = 1;
    repeat (3) @(negedge clock);
    checks++; if (aguardando !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", aguardando); end
    reset = 0; botaoPlaca = 1;
    #1;
    checks++; if (obs !== 36'h0) begin errors++; $display("FAIL mid_async obs=%h exp=%h", obs, 36'h0); end
    repeat (10) begin
      @(negedge clock);
      checks++; if (obs !== 36'h0) begin errors++; $display("FAIL mid_hold obs=%h exp=%h", obs, 36'h0); end
    end
    botaoPlaca = 0; cpu_if.pedidoIN = 0;
    @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    cpu_if.pedidoIN = 1;
    for (int k = 0; k < 24; k++) begin
      if (k == 4) botaoPlaca = 1;
      if (k == 16) botaoPlaca = 0;
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_after obs=%h exp=%h", obs, exp_v); end
      if (cpu_if.liberaParada) np++;
    end
    checks++; if (np !== 1) begin errors++; $display("FAIL mid_pulses got=%0d exp=1", np); end
    checks++; if (cpu_if.dadoLido !== 32'h9) begin errors++; $display("FAIL mid_data got=%h exp=00000009", cpu_if.dadoLido); end
    cpu_if.pedidoIN = 0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_random();
    int hold = 0, np_dut = 0, np_mod = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL random_cycle k=%0d obs=%h exp=%h", k, obs, exp_v); end
      if (cpu_if.liberaParada) np_dut++;
      if (m_capture) np_mod++;
      if (hold == 0) begin botaoPlaca = 1'($urandom_range(0, 1)); hold = $urandom_range(1, 12); end
      else hold--;
      if ($urandom_range(0, 29) == 0) cpu_if.pedidoIN = ~cpu_if.pedidoIN;
      sw = 4'($urandom);
      reset = ($urandom_range(0, 399) != 0);
    end
    reset = 1; cpu_if.pedidoIN = 0; botaoPlaca = 0;
    repeat (10) begin
      @(negedge clock);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL random_tail obs=%h exp=%h", obs, exp_v); end
    end
    checks++; if (np_dut !== np_mod) begin errors++; $display("FAIL random_pulses got=%0d exp=%0d", np_dut, np_mod); end
  endtask

  initial begin
    cpu_if.pedidoIN = 0;
    test_reset();
    test_basic();
    test_bounce();
    test_held();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
